// File: rtl/int_controller.sv
// Eight-source interrupt request controller: edge detect, pending latch, mask,
// fixed lowest-index priority and a request/acknowledge/return handshake.
module int_controller #(
    parameter int                 NUM_SRC  = 8,
    parameter logic [NUM_SRC-1:0] MASK_RST = 8'hFF
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] IrqIn,
    input  logic               MaskWr,
    input  logic [NUM_SRC-1:0] MaskIn,
    input  logic               IntAck,
    input  logic               IntDone,
    output logic               IntReq,
    output logic [7:0]         Int,
    output logic [NUM_SRC-1:0] Pending,
    output logic               Busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [7:0]         int_q, int_d;
    logic               intreq_q, intreq_d;
    logic               busy_q, busy_d;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] clr_s;

    // Scanning from the top down leaves the lowest set index as the winner.
    function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = v[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    assign rise_s     = IrqIn & ~irq_prev_q;
    assign eligible_s = pending_q & mask_q;

    // Next-state, pending update and registered-output next values.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        clr_s   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible_s) begin
                    sel_d   = lowest_idx(eligible_s);
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (IntAck) begin
                    clr_s[sel_q] = 1'b1;
                    state_d      = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (IntDone) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge on the bit being acknowledged keeps it pending.
        pending_d = (pending_q & ~clr_s) | rise_s;
        mask_d    = MaskWr ? MaskIn : mask_q;
        int_d     = (state_d == ST_IDLE) ? 8'h00 : {5'b00000, sel_d};
        intreq_d  = (state_d == ST_REQ);
        busy_d    = (state_d == ST_SERVICE);
    end

    // State, pending/mask and output registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= MASK_RST;
            int_q      <= 8'h00;
            intreq_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            irq_prev_q <= IrqIn;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_q      <= int_d;
            intreq_q   <= intreq_d;
            busy_q     <= busy_d;
        end
    end

    assign IntReq  = intreq_q;
    assign Int     = int_q;
    assign Pending = pending_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed handshake sequences with a
// queue of expected grant codes popped whenever the DUT raises IntReq.
module tb_int_controller;

    logic       CLK;
    logic       Reset;
    logic [7:0] IrqIn;
    logic       MaskWr;
    logic [7:0] MaskIn;
    logic       IntAck;
    logic       IntDone;
    logic       IntReq;
    logic [7:0] Int;
    logic [7:0] Pending;
    logic       Busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    int_controller #(.NUM_SRC(8), .MASK_RST(8'hFF)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .IrqIn  (IrqIn),
        .MaskWr (MaskWr),
        .MaskIn (MaskIn),
        .IntAck (IntAck),
        .IntDone(IntDone),
        .IntReq (IntReq),
        .Int    (Int),
        .Pending(Pending),
        .Busy   (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) for a request, then compare Int with the oldest expected code.
    task automatic wait_req(input string tag);
        int         n;
        logic [7:0] e;
        n = 0;
        while (IntReq !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_val({tag, "_req"}, IntReq, 32'd1);
        check_val({tag, "_sb_nonempty"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(tag, Int, e);
        end
    endtask

    task automatic serve();
        IntAck = 1'b1;
        tick();
        IntAck  = 1'b0;
        IntDone = 1'b1;
        tick();
        IntDone = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        IrqIn   = 8'h00;
        MaskWr  = 1'b0;
        MaskIn  = 8'h00;
        IntAck  = 1'b0;
        IntDone = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        check_val("rst_intreq", IntReq, 32'd0);
        check_val("rst_int", Int, 32'h00);
        check_val("rst_pending", Pending, 32'h00);
        check_val("rst_busy", Busy, 32'd0);

        // Single source 5, exact latency.
        IrqIn = 8'h20;
        exp_q.push_back(8'h05);
        tick();
        IrqIn = 8'h00;
        check_val("t1_pending", Pending, 32'h20);
        check_val("t1_req_early", IntReq, 32'd0);
        tick();
        check_val("t1_req_lat", IntReq, 32'd1);
        wait_req("t1_int");
        check_val("t1_or_merge", Int | 8'd19, 32'd23);
        IntAck = 1'b1;
        tick();
        IntAck = 1'b0;
        check_val("t1_ack_pending", Pending, 32'h00);
        check_val("t1_ack_busy", Busy, 32'd1);
        check_val("t1_ack_intreq", IntReq, 32'd0);
        check_val("t1_ack_int_held", Int, 32'h05);
        IntDone = 1'b1;
        tick();
        IntDone = 1'b0;
        check_val("t1_done_int", Int, 32'h00);
        check_val("t1_done_busy", Busy, 32'd0);

        // Two simultaneous sources: lowest index first.
        IrqIn = 8'h0A;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        tick();
        IrqIn = 8'h00;
        tick();
        wait_req("t2_first");
        serve();
        check_val("t2_gap_req", IntReq, 32'd0);
        tick();
        check_val("t2_rereq", IntReq, 32'd1);
        wait_req("t2_second");
        serve();

        // Masked source stays pending but unrequested.
        MaskWr = 1'b1;
        MaskIn = 8'hFE;
        tick();
        MaskWr = 1'b0;
        IrqIn  = 8'h01;
        tick();
        IrqIn = 8'h00;
        repeat (2) tick();
        check_val("t3_pending", Pending, 32'h01);
        check_val("t3_masked_req", IntReq, 32'd0);
        exp_q.push_back(8'h00);
        MaskWr = 1'b1;
        MaskIn = 8'hFF;
        tick();
        MaskWr = 1'b0;
        check_val("t3_unmask_edge_req", IntReq, 32'd0);
        tick();
        check_val("t3_unmask_req", IntReq, 32'd1);
        wait_req("t3_int");
        serve();

        // Committed selection is not pre-empted.
        IrqIn = 8'h10;
        exp_q.push_back(8'h04);
        tick();
        IrqIn = 8'h00;
        tick();
        wait_req("t4_first");
        IrqIn = 8'h02;
        exp_q.push_back(8'h01);
        tick();
        IrqIn = 8'h00;
        check_val("t4_hold_int", Int, 32'h04);
        check_val("t4_pending", Pending, 32'h12);
        tick();
        check_val("t4_hold_int2", Int, 32'h04);
        serve();
        wait_req("t4_second");
        serve();

        // Re-pulse on the ack cycle: set wins over clear.
        IrqIn = 8'h04;
        exp_q.push_back(8'h02);
        tick();
        IrqIn = 8'h00;
        tick();
        wait_req("t5_first");
        IrqIn  = 8'h04;
        IntAck = 1'b1;
        exp_q.push_back(8'h02);
        tick();
        IrqIn  = 8'h00;
        IntAck = 1'b0;
        check_val("t5_set_wins", Pending, 32'h04);
        check_val("t5_busy", Busy, 32'd1);
        IntDone = 1'b1;
        tick();
        IntDone = 1'b0;
        wait_req("t5_second");
        serve();

        // Async reset while in REQ with line 3 held high.
        IrqIn = 8'h08;
        repeat (2) tick();
        check_val("t6_pre_req", IntReq, 32'd1);
        check_val("t6_pre_int", Int, 32'h03);
        #2;
        Reset = 1'b1;
        #1;
        check_val("t6_async_req", IntReq, 32'd0);
        check_val("t6_async_int", Int, 32'h00);
        check_val("t6_async_pending", Pending, 32'h00);
        check_val("t6_async_busy", Busy, 32'd0);
        tick();
        Reset = 1'b0;
        exp_q.push_back(8'h03);
        tick();
        check_val("t6_rel_pending", Pending, 32'h08);
        wait_req("t6_int");
        serve();
        repeat (3) tick();
        check_val("t6_no_retrigger_pend", Pending, 32'h00);
        check_val("t6_no_retrigger_req", IntReq, 32'd0);
        IrqIn = 8'h00;
        tick();

        check_val("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
